// File: rtl/logip_pkg.sv
// Shared definitions for the logic-analyzer trigger stages: config word layout,
// decoded config struct and the stage FSM encoding.
package logip_pkg;

    localparam int CFG_DELAY_LSB  = 0;
    localparam int CFG_LEVEL_LSB  = 16;
    localparam int CFG_CHAN_LSB   = 20;
    localparam int CFG_SERIAL_BIT = 26;
    localparam int CFG_START_BIT  = 27;
    localparam int CFG_EDGE_BIT   = 28;

    typedef struct packed {
        logic        edge_en;
        logic        start;
        logic        serial;
        logic [4:0]  channel;
        logic [1:0]  level;
        logic [15:0] delay;
    } trg_cfg_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        FIRE  = 3'd3,
        DONE  = 3'd4
    } trg_state_e;

    function automatic trg_cfg_t decode_cfg(input logic [31:0] cmd);
        trg_cfg_t c;
        c.delay   = cmd[CFG_DELAY_LSB +: 16];
        c.level   = cmd[CFG_LEVEL_LSB +: 2];
        c.channel = cmd[CFG_CHAN_LSB +: 5];
        c.serial  = cmd[CFG_SERIAL_BIT];
        c.start   = cmd[CFG_START_BIT];
        c.edge_en = cmd[CFG_EDGE_BIT];
        return c;
    endfunction

endpackage

// File: rtl/trg_cmp.sv
// Mask/value comparator with optional rising-edge qualification of the match
// condition. Purely combinational; the previous condition is held by the caller.
module trg_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             edge_i,
    input  logic             stb_i,
    input  logic             prev_i,
    output logic             cond_o,
    output logic             hit_o
);

    // Masked-off bits never disqualify, so an all-zero mask always matches.
    assign cond_o = (((src_i ^ value_i) & mask_i) == '0);
    assign hit_o  = stb_i & cond_o & ~(edge_i & prev_i);

endmodule

// File: rtl/trg_stage_param.sv
// One trigger stage: config registers, serial channel shifter, delay counter and
// the IDLE/ARMED/DELAY/FIRE/DONE sequencer producing registered match/run pulses.
module trg_stage_param
    import logip_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DELAY_W = 16,
    parameter int LVL_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic [WIDTH-1:0]   input_i,
    input  logic               stb_i,
    input  logic [31:0]        cmd_i,
    input  logic               wr_mask_i,
    input  logic               wr_value_i,
    input  logic               wr_config_i,
    input  logic               arm_i,
    input  logic [LVL_W-1:0]   lvl_i,
    output logic               match_o,
    output logic               run_o,
    output trg_state_e         dbg_state_o,
    output logic [DELAY_W-1:0] dbg_cnt_o
);

    // Sample interface: stb_i qualifies input_i for exactly that cycle; there is
    // no back-pressure, every strobed sample is consumed in the cycle it appears.

    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   value_q;
    trg_cfg_t           cfg_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_nxt;
    logic [WIDTH-1:0]   src;
    logic               prev_q;
    logic [DELAY_W-1:0] cnt_q;
    trg_state_e         state_q;
    logic               ch_bit;
    logic               cond;
    logic               hit;
    logic [DELAY_W-1:0] delay_val;
    logic [LVL_W-1:0]   level_val;

    assign delay_val = cfg_q.delay[DELAY_W-1:0];
    assign level_val = LVL_W'(cfg_q.level);

    // Out-of-range channel numbers fall back to bit 0.
    always_comb begin
        ch_bit = input_i[0];
        for (int i = 1; i < WIDTH; i++) begin
            if (cfg_q.channel == 5'(i)) ch_bit = input_i[i];
        end
    end

    generate
        if (WIDTH == 1) begin : g_shreg_1
            assign shreg_nxt = ch_bit;
        end else begin : g_shreg_n
            assign shreg_nxt = {shreg_q[WIDTH-2:0], ch_bit};
        end
    endgenerate

    // Serial mode compares the history including the bit arriving this strobe.
    assign src = cfg_q.serial ? shreg_nxt : input_i;

    trg_cmp #(.WIDTH(WIDTH)) u_cmp (
        .src_i   (src),
        .value_i (value_q),
        .mask_i  (mask_q),
        .edge_i  (cfg_q.edge_en),
        .stb_i   (stb_i),
        .prev_i  (prev_q),
        .cond_o  (cond),
        .hit_o   (hit)
    );

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            mask_q  <= '0;
            value_q <= '0;
            cfg_q   <= '0;
        end else begin
            if (wr_mask_i)   mask_q  <= cmd_i[WIDTH-1:0];
            if (wr_value_i)  value_q <= cmd_i[WIDTH-1:0];
            if (wr_config_i) cfg_q   <= decode_cfg(cmd_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            shreg_q <= '0;
            match_o <= 1'b0;
            run_o   <= 1'b0;
        end else if (!arm_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            shreg_q <= '0;
            match_o <= 1'b0;
            run_o   <= 1'b0;
        end else begin
            match_o <= 1'b0;
            run_o   <= 1'b0;
            if (stb_i) begin
                shreg_q <= shreg_nxt;
                prev_q  <= cond;
            end
            case (state_q)
                IDLE: begin
                    if (lvl_i >= level_val) state_q <= ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        if (delay_val == '0) begin
                            state_q <= FIRE;
                            match_o <= 1'b1;
                            run_o   <= cfg_q.start;
                        end else begin
                            cnt_q   <= delay_val;
                            state_q <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (stb_i) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == DELAY_W'(1)) begin
                            state_q <= FIRE;
                            match_o <= 1'b1;
                            run_o   <= cfg_q.start;
                        end
                    end
                end
                FIRE:    state_q <= DONE;
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_trg_stage_param.sv
// Directed bench for trg_stage_param (8-bit instance): a vector table for the
// single-strobe compare path plus hand-written multi-cycle sequences.
module tb_trg_stage_param;
    import logip_pkg::*;

    localparam int W = 8;

    logic             clk_i = 1'b0;
    logic             rst_in;
    logic [W-1:0]     input_i;
    logic             stb_i;
    logic [31:0]      cmd_i;
    logic             wr_mask_i;
    logic             wr_value_i;
    logic             wr_config_i;
    logic             arm_i;
    logic [1:0]       lvl_i;
    logic             match_o;
    logic             run_o;
    trg_state_e       dbg_state_o;
    logic [15:0]      dbg_cnt_o;

    int n_vec  = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];

    trg_stage_param #(.WIDTH(W), .DELAY_W(16), .LVL_W(2)) dut (
        .clk_i       (clk_i),
        .rst_in      (rst_in),
        .input_i     (input_i),
        .stb_i       (stb_i),
        .cmd_i       (cmd_i),
        .wr_mask_i   (wr_mask_i),
        .wr_value_i  (wr_value_i),
        .wr_config_i (wr_config_i),
        .arm_i       (arm_i),
        .lvl_i       (lvl_i),
        .match_o     (match_o),
        .run_o       (run_o),
        .dbg_state_o (dbg_state_o),
        .dbg_cnt_o   (dbg_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  value;
        logic [31:0] cfg;
        logic [7:0]  sample;
        logic        exp_m;
        logic        exp_r;
    } vec_t;

    function automatic logic [31:0] mk_cfg(input logic [15:0] dly, input logic [1:0] lvl,
                                           input logic [4:0] chan, input logic ser,
                                           input logic st, input logic edg);
        return {3'b000, edg, st, ser, 1'b0, chan, 2'b00, lvl, dly};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input trg_state_e exp_st, input logic [15:0] exp_cnt);
        check({name, "_state"}, 32'(dbg_state_o), 32'(exp_st));
        check({name, "_cnt"}, 32'(dbg_cnt_o), 32'(exp_cnt));
    endtask

    task automatic idle_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] cmd, input logic wm, input logic wv, input logic wc);
        cmd_i = cmd;
        wr_mask_i = wm;
        wr_value_i = wv;
        wr_config_i = wc;
        @(posedge clk_i);
        #1;
        wr_mask_i = 1'b0;
        wr_value_i = 1'b0;
        wr_config_i = 1'b0;
    endtask

    // One cycle of stimulus; outputs are compared just after the closing edge.
    task automatic drive(input logic stb, input logic [7:0] d, input logic em, input logic er,
                         input string name);
        logic [1:0] e;
        stb_i = stb;
        input_i = d;
        exp_q.push_back({em, er});
        @(posedge clk_i);
        #1;
        stb_i = 1'b0;
        e = exp_q.pop_front();
        check(name, {30'b0, match_o, run_o}, {30'b0, e});
    endtask

    // Disarm, load mask/value/config, then re-arm for one quiet cycle.
    task automatic setup(input logic [7:0] m, input logic [7:0] v, input logic [31:0] c);
        arm_i = 1'b0;
        idle_cycle();
        wr({24'b0, m}, 1'b1, 1'b0, 1'b0);
        wr({24'b0, v}, 1'b0, 1'b1, 1'b0);
        wr(c, 1'b0, 1'b0, 1'b1);
        arm_i = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, "arm_quiet");
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic [3:0] bits;

        vecs[0] = '{8'hFF, 8'h5A, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0), 8'h5A, 1'b1, 1'b1};
        vecs[1] = '{8'hFF, 8'h5A, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0), 8'h5B, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 8'h5A, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0), 8'hAA, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 8'h5A, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0), 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0), 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 8'h81, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0), 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 8'h01, mk_cfg(16'd0, 2'd0, 5'd20, 1'b1, 1'b1, 1'b0), 8'h01, 1'b1, 1'b1};
        vecs[7] = '{8'h01, 8'h01, mk_cfg(16'd0, 2'd0, 5'd7, 1'b1, 1'b1, 1'b0), 8'h80, 1'b1, 1'b1};

        rst_in = 1'b0;
        input_i = '0;
        stb_i = 1'b0;
        cmd_i = '0;
        wr_mask_i = 1'b0;
        wr_value_i = 1'b0;
        wr_config_i = 1'b0;
        arm_i = 1'b0;
        lvl_i = 2'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_match", 32'(match_o), 32'd0);
        check("rst_run", 32'(run_o), 32'd0);
        check_state("rst", IDLE, 16'd0);
        rst_in = 1'b1;
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            setup(vecs[i].mask, vecs[i].value, vecs[i].cfg);
            check_state($sformatf("vec%0d_armed", i), ARMED, 16'd0);
            drive(1'b1, vecs[i].sample, vecs[i].exp_m, vecs[i].exp_r, $sformatf("vec%0d_pulse", i));
            drive(1'b0, 8'h00, 1'b0, 1'b0, $sformatf("vec%0d_after", i));
        end

        // Delay 3, strobes every other cycle after the hit.
        setup(8'hFF, 8'h5A, mk_cfg(16'd3, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "dly_hit");
        check_state("dly_load", DELAY, 16'd3);
        drive(1'b0, 8'h5A, 1'b0, 1'b0, "dly_gap0");
        drive(1'b1, 8'h00, 1'b0, 1'b0, "dly_s1");
        drive(1'b0, 8'h00, 1'b0, 1'b0, "dly_gap1");
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "dly_s2");
        check_state("dly_s2", DELAY, 16'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, "dly_gap2");
        drive(1'b1, 8'h11, 1'b1, 1'b1, "dly_s3_fire");
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "dly_done");
        check_state("dly_done", DONE, 16'd0);

        // Serial on channel 4; other bits and unstrobed cycles are noise.
        setup(8'h0F, 8'h0B, mk_cfg(16'd0, 2'd0, 5'd4, 1'b1, 1'b1, 1'b0));
        bits = 4'b1011;
        for (int k = 3; k >= 0; k--) begin
            d = 8'($urandom_range(0, 255));
            drive(1'b0, d, 1'b0, 1'b0, "ser_noise");
            d = 8'($urandom_range(0, 255));
            d[4] = bits[k];
            drive(1'b1, d, (k == 0), (k == 0), $sformatf("ser_shift%0d", 3 - k));
        end

        // Edge mode, bit0 held high: only the first strobe fires.
        setup(8'h01, 8'h01, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 5; k++) drive(1'b1, 8'h01, (k == 0), 1'b0, "edge_hold");
        setup(8'h01, 8'h01, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++) drive(1'b1, 8'h01, (k == 0), 1'b0, "level_hold");

        // Edge mode: condition already true before ARMED is not an edge.
        lvl_i = 2'd0;
        setup(8'h01, 8'h01, mk_cfg(16'd0, 2'd1, 5'd0, 1'b0, 1'b1, 1'b1));
        drive(1'b1, 8'h01, 1'b0, 1'b0, "edge_pre");
        check_state("edge_pre", IDLE, 16'd0);
        lvl_i = 2'd1;
        drive(1'b0, 8'h01, 1'b0, 1'b0, "edge_arm");
        drive(1'b1, 8'h01, 1'b0, 1'b0, "edge_still_high");
        drive(1'b1, 8'h00, 1'b0, 1'b0, "edge_low");
        drive(1'b1, 8'h01, 1'b1, 1'b1, "edge_rise");

        // Level gate, and lvl drop after ARMED does not disarm.
        lvl_i = 2'd1;
        setup(8'hFF, 8'h5A, mk_cfg(16'd0, 2'd2, 5'd0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "lvl_low0");
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "lvl_low1");
        check_state("lvl_low", IDLE, 16'd0);
        lvl_i = 2'd2;
        drive(1'b0, 8'h00, 1'b0, 1'b0, "lvl_arm");
        lvl_i = 2'd0;
        drive(1'b1, 8'h5A, 1'b1, 1'b1, "lvl_fire");

        // Abort mid-delay by dropping arm.
        lvl_i = 2'd0;
        setup(8'hFF, 8'h5A, mk_cfg(16'd100, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "abort_hit");
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "abort_s1");
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "abort_s2");
        check_state("abort_mid", DELAY, 16'd98);
        arm_i = 1'b0;
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "abort_drop");
        check_state("abort_drop", IDLE, 16'd0);
        for (int k = 0; k < 3; k++) drive(1'b1, 8'h5A, 1'b0, 1'b0, "abort_quiet");

        // Asynchronous reset mid-delay and while a pulse is showing.
        setup(8'hFF, 8'h5A, mk_cfg(16'd100, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h5A, 1'b0, 1'b0, "rstd_hit");
        rst_in = 1'b0;
        #1;
        check_state("rstd_async", IDLE, 16'd0);
        idle_cycle();
        rst_in = 1'b1;
        setup(8'hFF, 8'h5A, mk_cfg(16'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h5A, 1'b1, 1'b1, "rstp_fire");
        rst_in = 1'b0;
        #1;
        check("rstp_match", 32'(match_o), 32'd0);
        check("rstp_run", 32'(run_o), 32'd0);
        idle_cycle();
        rst_in = 1'b1;
        // Config was cleared: mask 0 matches anything, start 0 keeps run low.
        drive(1'b0, 8'h00, 1'b0, 1'b0, "post_rst_arm");
        drive(1'b1, 8'h3C, 1'b1, 1'b0, "post_rst_mask0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
